// File: rtl/uart_resp_transmitter.sv
// Serializes one 5-byte response frame (cmd, addr LSB/MSB, data LSB/MSB) per
// valid/ready handshake as back-to-back 8N1 bytes at a 16x oversampled baud.
module uart_resp_transmitter #(
   parameter int DVSR    = 22,
   parameter int SB_TICK = 16
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        rsp_valid,
   output logic        rsp_ready,
   input  logic [7:0]  rsp_cmd,
   input  logic [15:0] rsp_addr,
   input  logic [15:0] rsp_data,
   output logic        tx,
   output logic        busy,
   output logic        frame_done
);
   // DVSR=1 would give a zero-width divider; stop ticks beyond 16 need a wider counter.
   localparam int DW = (DVSR > 1) ? $clog2(DVSR) : 1;
   localparam int TW = (SB_TICK > 16) ? $clog2(SB_TICK) : 4;
   localparam logic [DW-1:0] DIV_LAST  = DW'(DVSR - 1);
   localparam logic [TW-1:0] TICK_LAST = TW'(15);
   localparam logic [TW-1:0] STOP_LAST = TW'(SB_TICK - 1);

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

   state_t        state_q;
   logic [DW-1:0] div_q, div_d;
   logic          os_tick;
   logic [TW-1:0] tick_q;
   logic [2:0]    bit_q;
   logic [2:0]    byte_q;
   logic [7:0]    frame_q [5];
   logic [7:0]    cur_byte;
   logic          tx_q, ready_q, done_q;

   always_comb begin
      os_tick = (div_q == DIV_LAST);
      div_d   = os_tick ? '0 : div_q + DW'(1);
   end

   always_comb begin
      cur_byte = frame_q[0];
      case (byte_q)
         3'd1:    cur_byte = frame_q[1];
         3'd2:    cur_byte = frame_q[2];
         3'd3:    cur_byte = frame_q[3];
         3'd4:    cur_byte = frame_q[4];
         default: cur_byte = frame_q[0];
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         div_q   <= '0;
         tick_q  <= '0;
         bit_q   <= '0;
         byte_q  <= '0;
         tx_q    <= 1'b1;
         ready_q <= 1'b1;
         done_q  <= 1'b0;
      end else begin
         done_q <= 1'b0;
         if (state_q != IDLE) div_q <= div_d;
         case (state_q)
            IDLE: begin
               if (rsp_valid) begin
                  frame_q[0] <= rsp_cmd;
                  frame_q[1] <= rsp_addr[7:0];
                  frame_q[2] <= rsp_addr[15:8];
                  frame_q[3] <= rsp_data[7:0];
                  frame_q[4] <= rsp_data[15:8];
                  div_q      <= '0;
                  tick_q     <= '0;
                  bit_q      <= '0;
                  byte_q     <= '0;
                  tx_q       <= 1'b0;
                  ready_q    <= 1'b0;
                  state_q    <= START;
               end
            end
            START: begin
               if (os_tick) begin
                  if (tick_q == TICK_LAST) begin
                     tick_q  <= '0;
                     bit_q   <= '0;
                     tx_q    <= cur_byte[0];
                     state_q <= DATA;
                  end else begin
                     tick_q <= tick_q + TW'(1);
                  end
               end
            end
            DATA: begin
               if (os_tick) begin
                  if (tick_q == TICK_LAST) begin
                     tick_q <= '0;
                     if (bit_q == 3'd7) begin
                        tx_q    <= 1'b1;
                        state_q <= STOP;
                     end else begin
                        bit_q <= bit_q + 3'd1;
                        tx_q  <= cur_byte[bit_q + 3'd1];
                     end
                  end else begin
                     tick_q <= tick_q + TW'(1);
                  end
               end
            end
            STOP: begin
               if (os_tick) begin
                  if (tick_q == STOP_LAST) begin
                     tick_q <= '0;
                     // Next start bit follows the stop bit with no gap.
                     if (byte_q == 3'd4) begin
                        ready_q <= 1'b1;
                        done_q  <= 1'b1;
                        state_q <= IDLE;
                     end else begin
                        byte_q  <= byte_q + 3'd1;
                        tx_q    <= 1'b0;
                        state_q <= START;
                     end
                  end else begin
                     tick_q <= tick_q + TW'(1);
                  end
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign tx         = tx_q;
   assign rsp_ready  = ready_q;
   assign busy       = ~ready_q;
   assign frame_done = done_q;

endmodule
